// File: rtl/aes_inv_shiftrows_serial_pkg.sv
// Shared AES constants, FSM encoding and the column-index helper for the
// serial InvShiftRows block.
package aes_inv_shiftrows_serial_pkg;

  localparam int AES_NB     = 4;
  localparam int AES_BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_LOAD  = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  // Input column that feeds output column col in row row: (col - row) mod 4.
  function automatic logic [1:0] inv_src_col(input logic [1:0] col, input logic [1:0] row);
    return col - row;
  endfunction

endpackage

// File: rtl/aes_inv_shiftrows_serial.sv
// Column-serial AES InvShiftRows: collects four 32-bit columns, then replays
// them with each row rotated right by its row index.
module aes_inv_shiftrows_serial
  import aes_inv_shiftrows_serial_pkg::*;
#(
  parameter int COLS  = 4,
  parameter int COL_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [COL_W-1:0] in_col,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COL_W-1:0] out_col,
  output logic             busy
);

  state_e                  state_r;
  state_e                  state_nxt_s;
  logic [1:0]              cnt_r;
  logic [1:0]              cnt_nxt_s;
  logic                    in_fire_s;
  logic [COL_W-1:0]        out_col_s;
  logic [AES_BYTE_W-1:0]   blk_r [COLS*AES_NB];

  // Next-state, handshake and counter logic; flush wins over any transfer.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    in_fire_s   = 1'b0;
    case (state_r)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          in_fire_s = 1'b1;
          cnt_nxt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_LOAD;
          end
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cnt_nxt_s = cnt_r + 2'd1;
          if (cnt_r == 2'd3) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_LOAD;
        cnt_nxt_s   = 2'd0;
      end
    endcase
    if (flush) begin
      state_nxt_s = ST_LOAD;
      cnt_nxt_s   = 2'd0;
      in_fire_s   = 1'b0;
    end else begin
      in_fire_s   = in_fire_s;
    end
  end

  // State, counter and byte buffer; buffer is written in place, never shifted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LOAD;
      cnt_r   <= 2'd0;
      for (int i = 0; i < COLS*AES_NB; i++) begin
        blk_r[i] <= '0;
      end
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (in_fire_s) begin
        for (int r = 0; r < AES_NB; r++) begin
          blk_r[{cnt_r, r[1:0]}] <= in_col[COL_W-1-AES_BYTE_W*r -: AES_BYTE_W];
        end
      end
    end
  end

  // Output byte select; forced to zero outside DRAIN so idle out_col is clean.
  always_comb begin
    out_col_s = '0;
    if (state_r == ST_DRAIN) begin
      for (int r = 0; r < AES_NB; r++) begin
        out_col_s[COL_W-1-AES_BYTE_W*r -: AES_BYTE_W] =
          blk_r[{inv_src_col(cnt_r, r[1:0]), r[1:0]}];
      end
    end else begin
      out_col_s = '0;
    end
  end

  assign out_col = out_col_s;
  assign busy    = !((state_r == ST_LOAD) && (cnt_r == 2'd0));

endmodule

// File: tb/tb_aes_inv_shiftrows_serial.sv
// Self-checking bench for aes_inv_shiftrows_serial: directed table, corner
// sequences and a randomized ShiftRows -> InvShiftRows round trip.
module tb_aes_inv_shiftrows_serial;

  typedef logic [31:0] cols_t [4];
  typedef struct {
    cols_t cin;
    cols_t cexp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_col = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_col;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  aes_inv_shiftrows_serial #(.COLS(4), .COL_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_col(in_col),
    .out_valid(out_valid), .out_ready(out_ready), .out_col(out_col),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: view a block as a 4x4 byte matrix state[row][col].
  function automatic logic [7:0] get_byte(input cols_t c, input int col, input int row);
    logic [31:0] w;
    w = c[col];
    return w[31-8*row -: 8];
  endfunction

  // Forward AES ShiftRows: row r rotated left by r.
  function automatic cols_t shift_rows(input cols_t s);
    cols_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][31-8*r -: 8] = get_byte(s, (c + r) % 4, r);
    return o;
  endfunction

  task automatic load_cols(input cols_t c, input int n, input string tag);
    int t;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_col   = c[i];
      t = 0;
      while (!in_ready && t < 20) begin
        step();
        t++;
      end
      chk({tag, " in_ready"}, {31'h0, in_ready}, 32'h1);
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_block(input cols_t cin, input cols_t cexp, input int bp, input string tag);
    int t;
    load_cols(cin, 4, tag);
    in_valid = 1'($urandom_range(0, 1));
    in_col   = $urandom;
    chk({tag, " latency"}, {31'h0, out_valid}, 32'h1);
    for (int j = 0; j < 4; j++) begin
      if (j == 0) begin
        for (int b = 0; b < bp; b++) begin
          out_ready = 1'b0;
          chk({tag, " hold"}, out_col, cexp[0]);
          chk({tag, " hold_valid"}, {31'h0, out_valid}, 32'h1);
          step();
        end
      end
      out_ready = 1'b1;
      t = 0;
      while (!out_valid && t < 20) begin
        step();
        t++;
      end
      chk({tag, " out_col"}, out_col, cexp[j]);
      if (j < 3) in_col = $urandom;
      step();
      if (j == 3) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    chk({tag, " in_ready_after"}, {31'h0, in_ready}, 32'h1);
    chk({tag, " out_valid_after"}, {31'h0, out_valid}, 32'h0);
  endtask

  vec_t vecs [3];

  initial begin
    int first_out [2];
    int blk_seen, in_idx, out_idx;
    cols_t s, sr;
    logic [31:0] stream_in [8];
    logic [31:0] stream_exp [8];

    vecs[0].cin  = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f};
    vecs[0].cexp = '{32'h000d0a07, 32'h04010e0b, 32'h0805020f, 32'h0c090603};
    vecs[1].cin  = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};
    vecs[1].cexp = '{32'h00ddaa77, 32'h4411eebb, 32'h885522ff, 32'hcc996633};
    vecs[2].cin  = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};
    vecs[2].cexp = '{32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff};

    // Reset state
    #12;
    chk("rst in_ready",  {31'h0, in_ready},  32'h1);
    chk("rst out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst busy",      {31'h0, busy},      32'h0);
    chk("rst out_col",   out_col,            32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed table
    for (int v = 0; v < 3; v++)
      run_block(vecs[v].cin, vecs[v].cexp, 0, $sformatf("vec%0d", v));

    // Back-pressure on first output
    run_block(vecs[0].cin, vecs[0].cexp, 3, "bp");

    // Streaming: two back-to-back blocks with everything held high
    for (int i = 0; i < 8; i++) begin
      stream_in[i]  = vecs[i/4].cin[i%4];
      stream_exp[i] = vecs[i/4].cexp[i%4];
    end
    in_idx = 0; out_idx = 0; blk_seen = 0;
    first_out[0] = -1; first_out[1] = -1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = (in_idx < 8);
      in_col   = (in_idx < 8) ? stream_in[in_idx] : 32'h0;
      if (in_ready && in_idx < 8) in_idx++;
      if (out_valid && out_idx < 8) begin
        if (out_idx % 4 == 0) first_out[out_idx/4] = cyc;
        chk("stream out_col", out_col, stream_exp[out_idx]);
        out_idx++;
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream outputs", out_idx, 32'd8);
    chk("stream first", first_out[0], 32'd4);
    chk("stream period", first_out[1] - first_out[0], 32'd8);

    // Flush after two columns, with a simultaneous transfer
    load_cols(vecs[1].cin, 2, "flush");
    flush = 1'b1;
    in_valid = 1'b1;
    in_col = vecs[1].cin[2];
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush busy", {31'h0, busy}, 32'h0);
    for (int i = 0; i < 6; i++) begin
      chk("flush out_valid", {31'h0, out_valid}, 32'h0);
      step();
    end
    run_block(vecs[0].cin, vecs[0].cexp, 0, "post_flush");

    // Reset in the middle of drain
    load_cols(vecs[1].cin, 4, "rstmid");
    out_ready = 1'b1;
    chk("rstmid out0", out_col, vecs[1].cexp[0]);
    step();
    out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmid out_valid", {31'h0, out_valid}, 32'h0);
    chk("rstmid in_ready",  {31'h0, in_ready},  32'h1);
    chk("rstmid busy",      {31'h0, busy},      32'h0);
    chk("rstmid out_col",   out_col,            32'h0);
    step();
    rst_n = 1'b1;
    run_block(vecs[0].cin, vecs[0].cexp, 0, "post_rst");

    // Round trip: random state -> ShiftRows model -> DUT must return the state
    for (int k = 0; k < 1000; k++) begin
      for (int c = 0; c < 4; c++) s[c] = $urandom;
      sr = shift_rows(s);
      run_block(sr, s, int'($urandom_range(0, 2)), "roundtrip");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule
